bbox_resampler: RTL and testbench
=================================

# bbox_resampler

Downstream stage of the bounding-box engine. Takes the packed box `{xMin, xMax, yMin, yMax}` and re-reads the 100x75 byte image RAM. It nearest-neighbour resamples the boxed region into a 16x16 binary map that later stages (digit classifier, Avalon readback) read one 16-bit row at a time. It is pure address arithmetic with no divider: output dimension is a power of two.

## Interface
- `IMG_W`, 100, image width in pixels (row stride of RAM)
- `IMG_H`, 75, image height in pixels
- `THRESH`, 8'd1, pixel is set when `ram_rddata >= THRESH`
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request; sampled only in IDLE
- `coordinates` in 32: xMin[31:24], xMax[23:16], yMin[15:8], yMax[7:0]; latched on accepted `start`
- `ram_addr` out 13: image RAM read address, `y*IMG_W + x`
- `ram_rddata` in 8: RAM data, valid exactly one cycle after `ram_addr`
- `row_sel` in 4: output row select
- `row_data` out 16: combinational view of map row `row_sel`; bit i = column i
- `busy` out 1: high whenever state != IDLE
- `done` out 1: one-cycle pulse at completion
- `error` out 1: box invalid on last run; held until next accepted `start` or `rst`

## Operation
- FSM states: IDLE, CHECK, ADDR, WAIT, SAMPLE, DONE.
- IDLE with `start=1`:
  - latch `coordinates`
  - clear map and `error`
  - zero i,j
  - go to CHECK
- `start` is ignored in every other state. `coordinates` changes after latch have no effect.
- CHECK:
  - Invalid if any of: xMin>xMax, yMin>yMax, xMax>=IMG_W, yMax>=IMG_H.
  - Invalid: set `error`, go to DONE, no RAM reads.
  - Valid: go to ADDR.
- Sample math:
  - w = xMax-xMin+1, h = yMax-yMin+1 (7 bits each)
  - sx = xMin + (((2i+1)*w) >> 5)
  - sy = yMin + (((2j+1)*h) >> 5)
  - Products fit in 12 bits, max 31*100 = 3100.
  - The result always lies inside the box.
- ram_addr computation: sy*100 computed as (sy<<6)+(sy<<5)+(sy<<2), plus sx. Maximum address is 7499.
- Per-sample sequence (row-major, j outer, i inner):
  - ADDR: drive `ram_addr`
  - WAIT: hold `ram_addr`
  - SAMPLE: capture `ram_rddata >= THRESH` into map[j][i], then advance i
  - on i wrap 15→0, advance j
- After i=15, j=15 SAMPLE, go to DONE.
- DONE: `done`=1 for that cycle, then IDLE. Map and `error` persist until next accepted start.
- `ram_addr` holds its last value in IDLE/CHECK/DONE; it is 0 after reset.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `error`=0, `ram_addr`=0
  - all map rows 0, so `row_data`=0
- `rst` mid-run aborts immediately to the reset values. A start on the first cycle after `rst` deasserts is accepted.
- Let edge E0 be the edge that samples `start`.
  - Valid box: `busy` high from E0. Cycles run CHECK, then 256×3 sample cycles, then DONE. `done` is high in the cycle after edge E769.
  - Invalid box: `done` is high after edge E1.
- Each map bit updates on its SAMPLE edge. `row_data` for a row is final once that row's i=15 SAMPLE edge has passed.
- `start` held high continuously: a new run starts on the cycle after DONE (IDLE re-accepts it).

## Test plan
- All-255 image, box (0,99,0,74):
  - every `row_data` = 16'hFFFF, `error`=0, `done` after 769 cycles
  - first `ram_addr`=203 (sx=3, sy=2), last `ram_addr`=7296 (sx=96, sy=72)
- Box (0,15,0,15), RAM = 255 only at (k,k) for k=0..15, 0 elsewhere:
  - sx=i, sy=j
  - `row_data` for row j = 16'h1 << j
- Single-pixel box (10,10,20,20), RAM[2010]=255:
  - every `ram_addr` = 2010
  - all rows 16'hFFFF
- Invalid box (50,40,0,10):
  - `error`=1, `done` after edge E1
  - `ram_addr` unchanged, all rows 0
  - then valid box (0,15,0,15) clears `error`
- `rst` asserted 300 cycles into a run:
  - next cycle `busy`=0, `done`=0, rows 0
  - a fresh start completes normally with the correct map
- `start` pulsed and `coordinates` changed while `busy`:
  - no restart, result matches the originally latched box
  - exactly one `done` pulse

Source files
------------

// File: rtl/bbox_resampler.sv
// Nearest-neighbour resampler: maps a bounding box of the image RAM onto a 16x16 binary map.
// Each sample takes three cycles (address, RAM latency, capture); rows are readable combinationally.
module bbox_resampler #(
    parameter int unsigned IMG_W  = 100,
    parameter int unsigned IMG_H  = 75,
    parameter logic [7:0]  THRESH = 8'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] coordinates_i,
    output logic [12:0] ram_addr_o,
    input  logic [7:0]  ram_rddata_i,
    input  logic [3:0]  row_sel_i,
    output logic [15:0] row_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);
    localparam logic [7:0] ImgW = 8'(IMG_W);
    localparam logic [7:0] ImgH = 8'(IMG_H);

    typedef enum logic [2:0] {StIdle, StCheck, StAddr, StWait, StSample, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       coord_q, coord_d;
    logic [7:0]        cnt_q, cnt_d;  // {j, i}
    logic [12:0]       addr_q, addr_d;
    logic              error_q, error_d;
    logic [15:0][15:0] map_q, map_d;

    logic [7:0]  x_min, x_max, y_min, y_max;
    logic [6:0]  w, h;
    logic [7:0]  nxt_cnt;
    logic [11:0] prod_x, prod_y;
    logic [7:0]  sx, sy;
    logic [12:0] nxt_addr;
    logic        box_bad;

    assign x_min = coord_q[31:24];
    assign x_max = coord_q[23:16];
    assign y_min = coord_q[15:8];
    assign y_max = coord_q[7:0];

    assign w = 7'(x_max - x_min) + 7'd1;
    assign h = 7'(y_max - y_min) + 7'd1;

    // Sample index whose address is loaded on the edge entering ADDR.
    assign nxt_cnt = (state_q == StSample) ? cnt_q + 8'd1 : cnt_q;

    assign prod_x   = 12'({nxt_cnt[3:0], 1'b1}) * 12'(w);
    assign prod_y   = 12'({nxt_cnt[7:4], 1'b1}) * 12'(h);
    assign sx       = x_min + 8'(prod_x >> 5);
    assign sy       = y_min + 8'(prod_y >> 5);
    // sy * 100 as shift-add: 64 + 32 + 4.
    assign nxt_addr = (13'(sy) << 6) + (13'(sy) << 5) + (13'(sy) << 2) + 13'(sx);

    assign box_bad = (x_min > x_max) || (y_min > y_max) || (x_max >= ImgW) || (y_max >= ImgH);

    always_comb begin
        state_d = state_q;
        coord_d = coord_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        error_d = error_q;
        map_d   = map_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    coord_d = coordinates_i;
                    error_d = 1'b0;
                    cnt_d   = 8'd0;
                    map_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (box_bad) begin
                    error_d = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = nxt_addr;
                    state_d = StAddr;
                end
            end
            StAddr: state_d = StWait;
            StWait: state_d = StSample;
            StSample: begin
                map_d[cnt_q[7:4]][cnt_q[3:0]] = (ram_rddata_i >= THRESH);
                if (cnt_q == 8'd255) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = nxt_cnt;
                    addr_d  = nxt_addr;
                    state_d = StAddr;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            coord_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            error_q <= 1'b0;
            map_q   <= '0;
        end else begin
            state_q <= state_d;
            coord_q <= coord_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            error_q <= error_d;
            map_q   <= map_d;
        end
    end

    assign ram_addr_o = addr_q;
    assign row_data_o = map_q[row_sel_i];
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign error_o    = error_q;

endmodule

// File: tb/tb_bbox_resampler.sv
// Bench for bbox_resampler: run-level reference model compared every cycle, plus literal checks.
module tb_bbox_resampler;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] coordinates_i = '0;
    logic [12:0] ram_addr_o;
    logic [7:0]  ram_rddata_i = '0;
    logic [3:0]  row_sel_i = '0;
    logic [15:0] row_data_o;
    logic        busy_o, done_o, error_o;

    bbox_resampler dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .coordinates_i(coordinates_i),
        .ram_addr_o   (ram_addr_o),
        .ram_rddata_i (ram_rddata_i),
        .row_sel_i    (row_sel_i),
        .row_data_o   (row_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:7499];
    always @(posedge clk) ram_rddata_i <= (ram_addr_o < 13'd7500) ? mem[ram_addr_o] : 8'h00;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_busy = 0, m_done = 0, m_err = 0;
    logic [12:0] m_addr = '0;
    logic [15:0] m_map [16];
    int          n = 0, m_len = 0;
    int          e_addr [256];
    bit          e_bit [256];
    bit          e_inv = 0;

    bit         force_en = 0;
    logic [3:0] force_row = '0;

    function automatic logic [31:0] box(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    function automatic bit box_invalid(input logic [31:0] c);
        return (c[31:24] > c[23:16]) || (c[15:8] > c[7:0]) || (c[23:16] >= 8'd100) ||
               (c[7:0] >= 8'd75);
    endfunction

    function automatic void plan(input logic [31:0] c);
        int x0, x1, y0, y1, sx, sy;
        x0 = int'(c[31:24]); x1 = int'(c[23:16]);
        y0 = int'(c[15:8]);  y1 = int'(c[7:0]);
        e_inv = box_invalid(c);
        for (int k = 0; k < 256; k++) begin
            sx = x0 + ((2 * (k % 16) + 1) * (x1 - x0 + 1)) / 32;
            sy = y0 + ((2 * (k / 16) + 1) * (y1 - y0 + 1)) / 32;
            e_addr[k] = sy * 100 + sx;
            e_bit[k]  = e_inv ? 1'b0 : (mem[e_addr[k]] >= 8'd1);
        end
    endfunction

    // Run-level timeline: E0 accepts, sample k addressed after E(3k+1), captured at E(3k+4).
    initial begin
        for (int r = 0; r < 16; r++) m_map[r] = '0;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                m_busy = 0; m_done = 0; m_err = 0; m_addr = '0;
                for (int r = 0; r < 16; r++) m_map[r] = '0;
            end else if (!m_busy) begin
                m_done = 0;
                if (start_i) begin
                    plan(coordinates_i);
                    m_busy = 1; n = 0; m_err = 0;
                    m_len = e_inv ? 1 : 769;
                    for (int r = 0; r < 16; r++) m_map[r] = '0;
                end
            end else begin
                n++;
                if (n == m_len + 1) begin
                    m_busy = 0; m_done = 0;
                end else begin
                    m_done = (n == m_len);
                    if (e_inv && n == 1) m_err = 1;
                    if (!e_inv && n % 3 == 1) begin
                        if (n >= 4) m_map[((n - 4) / 3) / 16][((n - 4) / 3) % 16] = e_bit[(n - 4) / 3];
                        if ((n - 1) / 3 < 256) m_addr = 13'(e_addr[(n - 1) / 3]);
                    end
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            row_sel_i = force_en ? force_row : 4'($urandom);
            #1;
            cmp("busy", 32'(busy_o), 32'(m_busy));
            cmp("done", 32'(done_o), 32'(m_done));
            cmp("error", 32'(error_o), 32'(m_err));
            cmp("ram_addr", 32'(ram_addr_o), 32'(m_addr));
            cmp("row_data", 32'(row_data_o), 32'(m_map[row_sel_i]));
        end
    end

    task automatic launch(input logic [31:0] c, input bit now, output int dk,
                          output logic [12:0] a1);
        if (!now) @(negedge clk);
        start_i = 1; coordinates_i = c; dk = -1; a1 = '0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k == 0) begin start_i = 0; coordinates_i = $urandom; end
            if (k == 1) a1 = ram_addr_o;
            if (done_o) begin dk = k; break; end
        end
        if (dk < 0) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: no done within 1000 cycles, want done");
        end
    endtask

    // mode 1: diagonal (1 << row), mode 0: constant val
    task automatic rows_lit(input string nm, input bit mode, input logic [15:0] val);
        logic [15:0] one;
        one = 16'h1;
        force_en = 1;
        for (int r = 0; r < 16; r++) begin
            force_row = 4'(r);
            @(negedge clk);
            #2;
            cmp(nm, 32'(row_data_o), 32'(mode ? (one << r) : val));
        end
        force_en = 0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 7500; a++) mem[a] = v;
    endtask

    task automatic fill_diag();
        fill(8'h00);
        for (int k = 0; k < 16; k++) mem[k * 100 + k] = 8'hFF;
    endtask

    int          dk, cnt, first;
    logic [12:0] a1;
    logic [31:0] c;
    int          x0, x1, y0, y1;

    initial begin
        fill(8'hFF);
        repeat (3) @(negedge clk);
        cmp("rst_busy", 32'(busy_o), 0);
        cmp("rst_done", 32'(done_o), 0);
        cmp("rst_error", 32'(error_o), 0);
        cmp("rst_addr", 32'(ram_addr_o), 0);
        cmp("rst_row", 32'(row_data_o), 0);
        rst_i = 0;

        // Full image, all set
        launch(box(0, 99, 0, 74), 0, dk, a1);
        cmp("full_done_cycle", 32'(dk), 769);
        cmp("full_first_addr", 32'(a1), 203);
        cmp("full_last_addr", 32'(ram_addr_o), 7296);
        cmp("full_error", 32'(error_o), 0);
        rows_lit("full_rows", 0, 16'hFFFF);

        // Diagonal: sx = i, sy = j
        fill_diag();
        launch(box(0, 15, 0, 15), 0, dk, a1);
        cmp("diag_done_cycle", 32'(dk), 769);
        cmp("diag_first_addr", 32'(a1), 0);
        rows_lit("diag_rows", 1, 16'h0);

        // Single pixel
        fill(8'h00);
        mem[2010] = 8'hFF;
        launch(box(10, 10, 20, 20), 0, dk, a1);
        cmp("pix_first_addr", 32'(a1), 2010);
        cmp("pix_last_addr", 32'(ram_addr_o), 2010);
        rows_lit("pix_rows", 0, 16'hFFFF);

        // Invalid box, then valid clears error
        launch(box(50, 40, 0, 10), 0, dk, a1);
        cmp("inv_done_cycle", 32'(dk), 1);
        cmp("inv_error", 32'(error_o), 1);
        cmp("inv_addr_held", 32'(ram_addr_o), 2010);
        rows_lit("inv_rows", 0, 16'h0);
        fill_diag();
        launch(box(0, 15, 0, 15), 0, dk, a1);
        cmp("inv_then_valid_error", 32'(error_o), 0);
        rows_lit("inv_then_valid_rows", 1, 16'h0);

        // Reset 300 cycles into a run, restart on the first cycle after reset
        @(negedge clk);
        start_i = 1; coordinates_i = box(0, 99, 0, 74);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) start_i = 0;
        end
        rst_i = 1;
        @(negedge clk);
        #2;
        cmp("midrst_busy", 32'(busy_o), 0);
        cmp("midrst_done", 32'(done_o), 0);
        cmp("midrst_row", 32'(row_data_o), 0);
        rst_i = 0;
        launch(box(0, 15, 0, 15), 1, dk, a1);
        cmp("midrst_restart_done", 32'(dk), 769);
        rows_lit("midrst_rows", 1, 16'h0);

        // Start pulse and coordinate change while busy
        @(negedge clk);
        start_i = 1; coordinates_i = box(0, 15, 0, 15); cnt = 0;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            if (k == 0) start_i = 0;
            if (k == 50) begin start_i = 1; coordinates_i = box(0, 99, 0, 74); end
            if (k == 51) start_i = 0;
            if (done_o) cnt++;
        end
        cmp("busy_restart_dones", 32'(cnt), 1);
        rows_lit("busy_restart_rows", 1, 16'h0);

        // Start held high: back-to-back runs
        fill(8'hFF);
        @(negedge clk);
        start_i = 1; coordinates_i = box(0, 99, 0, 74); cnt = 0; first = -1;
        for (int k = 0; k < 1700; k++) begin
            @(negedge clk);
            if (done_o) begin cnt++; if (first < 0) first = k; end
            if (first >= 0 && k == first + 3) start_i = 0;
        end
        start_i = 0;
        cmp("held_start_dones", 32'(cnt), 2);

        // Random images and boxes
        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < 7500; a++)
                mem[a] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            x0 = $urandom_range(0, 99); x1 = $urandom_range(x0, 99);
            y0 = $urandom_range(0, 74); y1 = $urandom_range(y0, 74);
            if (t % 4 == 3) y1 = $urandom_range(75, 255);
            if (t == 6) begin x0 = 60; x1 = 30; end
            c = box(x0, x1, y0, y1);
            launch(c, 0, dk, a1);
            cmp("rand_done_cycle", 32'(dk), box_invalid(c) ? 1 : 769);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
